// File: rtl/mult_hilo_ctrl.sv
// Sequencing and HI/LO result stage around the iterative 32-bit Booth multiplier.
// Latches operands, drives the run window and captures the product into HI/LO.
module mult_hilo_ctrl #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned RUN_EDGES = 34
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             op_ready,
    output logic [WIDTH-1:0] mult_mc,
    output logic [WIDTH-1:0] mult_mp,
    output logic [1:0]       mult_start,
    input  logic [WIDTH-1:0] mult_hi,
    input  logic [WIDTH-1:0] mult_lo,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W      = 6;
    localparam logic [CNT_W-1:0] CAPTURE_CNT = CNT_W'(RUN_EDGES - 1);
    localparam logic [1:0]  START_RUN  = 2'd2;
    localparam logic [1:0]  START_IDLE = 2'd0;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // busy/op_ready/mult_start are kept as flops that always track the state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            hi         <= '0;
            lo         <= '0;
            mult_mc    <= '0;
            mult_mp    <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
            op_ready   <= 1'b1;
            mult_start <= START_IDLE;
        end else begin
            done <= 1'b0;
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;

            case (state)
                IDLE: begin
                    if (op_valid) begin
                        mult_mc    <= op_a;
                        mult_mp    <= op_b;
                        cnt        <= '0;
                        state      <= RUN;
                        busy       <= 1'b1;
                        op_ready   <= 1'b0;
                        mult_start <= START_RUN;
                    end
                end
                RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    // Capture overrides any MTHI/MTLO write on the same edge.
                    if (cnt == CAPTURE_CNT) begin
                        hi         <= mult_hi;
                        lo         <= mult_lo;
                        done       <= 1'b1;
                        cnt        <= '0;
                        state      <= IDLE;
                        busy       <= 1'b0;
                        op_ready   <= 1'b1;
                        mult_start <= START_IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    cnt        <= '0;
                    busy       <= 1'b0;
                    op_ready   <= 1'b1;
                    mult_start <= START_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Scoreboard bench for mult_hilo_ctrl with a cycle-accurate behavioural multiplier.
module tb_mult_hilo_ctrl;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             reset;
    logic             op_valid;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_ready;
    logic [WIDTH-1:0] mult_mc;
    logic [WIDTH-1:0] mult_mp;
    logic [1:0]       mult_start;
    logic [WIDTH-1:0] mult_hi;
    logic [WIDTH-1:0] mult_lo;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    mult_hilo_ctrl #(.WIDTH(WIDTH), .RUN_EDGES(34)) dut (
        .clk        (clk),
        .reset      (reset),
        .op_valid   (op_valid),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_ready   (op_ready),
        .mult_mc    (mult_mc),
        .mult_mp    (mult_mp),
        .mult_start (mult_start),
        .mult_hi    (mult_hi),
        .mult_lo    (mult_lo),
        .hi_we      (hi_we),
        .lo_we      (lo_we),
        .wdata      (wdata),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   run_len = 0;
    int   bad_start = 0;
    int   bad_ready = 0;
    int   bad_opnd  = 0;
    int   bad_done  = 0;
    bit   skip_len  = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic exp_t mk_exp(input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint p;
        p    = longint'($signed(a)) * longint'($signed(b));
        e.a  = a;
        e.b  = b;
        e.hi = p[63:32];
        e.lo = p[31:0];
        return e;
    endfunction

    // Multiplier model: load edge, 32 iteration edges, product valid only afterwards.
    int          m_cnt = 0;
    logic [31:0] m_mc, m_mp;
    longint      m_p;
    always @(posedge clk) begin
        if (mult_start == 2'd2) begin
            if (m_cnt == 0) begin
                m_mc = mult_mc;
                m_mp = mult_mp;
            end
            m_cnt = m_cnt + 1;
            if (m_cnt >= 33) begin
                m_p = longint'($signed(m_mc)) * longint'($signed(m_mp));
                mult_hi <= m_p[63:32];
                mult_lo <= m_p[31:0];
            end else begin
                mult_hi <= 32'hA5A5_0000 ^ 32'(m_cnt);
                mult_lo <= 32'h5A5A_0000 ^ 32'(m_cnt);
            end
        end else begin
            m_cnt = 0;
            mult_hi <= 32'h0;
            mult_lo <= 32'h0;
        end
    end

    // Monitor: run-window invariants and scoreboard pop on done.
    always @(negedge clk) begin
        exp_t e;
        if (busy === 1'b1) begin
            run_len++;
            if (mult_start !== 2'd2) bad_start++;
            if (op_ready !== 1'b0) bad_ready++;
            if (done !== 1'b0) bad_done++;
            if (q.size() > 0 && (mult_mc !== q[0].a || mult_mp !== q[0].b)) bad_opnd++;
        end else begin
            if (run_len != 0) begin
                if (!skip_len) check_eq("busy_len", 64'(run_len), 64'd34);
                run_len = 0;
            end
            if (mult_start !== 2'd0) bad_start++;
            if (op_ready !== 1'b1) bad_ready++;
            if (done === 1'b1) begin
                if (q.size() == 0) check_eq("done_spurious", 64'd1, 64'd0);
                else begin
                    e = q.pop_front();
                    check_eq("prod_hi", 64'(hi), 64'(e.hi));
                    check_eq("prod_lo", 64'(lo), 64'(e.lo));
                end
            end
        end
    end

    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        op_a     = a;
        op_b     = b;
        op_valid = 1'b1;
        q.push_back(mk_exp(a, b));
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check_eq("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        reset    = 1'b0;
        op_valid = 1'b0;
        op_a     = '0;
        op_b     = '0;
        hi_we    = 1'b0;
        lo_we    = 1'b0;
        wdata    = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("rst_hi", 64'(hi), 64'd0);
        check_eq("rst_lo", 64'(lo), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_start", 64'(mult_start), 64'd0);
        check_eq("rst_ready", 64'(op_ready), 64'd1);

        start_op(32'd3, 32'd5);
        wait_done();
        start_op(32'hFFFF_FFFE, 32'd7);
        wait_done();
        start_op(32'h8000_0000, 32'h8000_0000);
        wait_done();

        // op_valid held high: second request taken on the edge after the done cycle
        op_a     = 32'd3;
        op_b     = 32'd5;
        op_valid = 1'b1;
        q.push_back(mk_exp(32'd3, 32'd5));
        @(negedge clk);
        op_a = 32'd4;
        op_b = 32'd6;
        q.push_back(mk_exp(32'd4, 32'd6));
        wait_done();
        check_eq("b2b_ready_done", 64'(op_ready), 64'd1);
        @(negedge clk);
        check_eq("b2b_accept", 64'(busy), 64'd1);
        op_valid = 1'b0;
        wait_done();
        check_eq("b2b_lo", 64'(lo), 64'h18);

        // MTLO write while idle
        lo_we = 1'b1;
        wdata = 32'hCAFE_F00D;
        @(negedge clk);
        lo_we = 1'b0;
        check_eq("mtlo_idle", 64'(lo), 64'hCAFE_F00D);

        // MTHI in RUN is visible until capture replaces it
        start_op(32'hFFFF_FFFE, 32'd7);
        repeat (9) @(negedge clk);
        hi_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        hi_we = 1'b0;
        check_eq("mthi_in_run", 64'(hi), 64'hDEAD_BEEF);
        wait_done();

        // Writes on the capture edge lose to the product
        start_op(32'd3, 32'd5);
        repeat (33) @(negedge clk);
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h1234_5678;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        check_eq("cap_wins_done", 64'(done), 64'd1);
        check_eq("cap_wins_hi", 64'(hi), 64'd0);
        check_eq("cap_wins_lo", 64'(lo), 64'hF);

        // Accept plus MTHI on the same idle edge
        hi_we = 1'b1;
        wdata = 32'h0000_0055;
        start_op(32'd6, 32'd7);
        hi_we = 1'b0;
        check_eq("accept_mthi_hi", 64'(hi), 64'h55);
        check_eq("accept_mthi_busy", 64'(busy), 64'd1);
        wait_done();

        // Reset mid-run aborts without capture
        start_op(32'd3, 32'd5);
        repeat (11) @(negedge clk);
        skip_len = 1'b1;
        reset    = 1'b0;
        q.delete();
        @(negedge clk);
        reset = 1'b1;
        check_eq("abort_busy", 64'(busy), 64'd0);
        check_eq("abort_hi", 64'(hi), 64'd0);
        check_eq("abort_lo", 64'(lo), 64'd0);
        check_eq("abort_start", 64'(mult_start), 64'd0);
        check_eq("abort_done", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        check_eq("abort_no_done", 64'(done), 64'd0);
        skip_len = 1'b0;
        start_op(32'd2, 32'd2);
        wait_done();
        check_eq("after_abort_lo", 64'(lo), 64'd4);

        for (int i = 0; i < 3; i++) begin
            start_op($urandom, $urandom);
            wait_done();
        end

        @(negedge clk);
        check_eq("sb_empty", 64'(q.size()), 64'd0);
        check_eq("start_code", 64'(bad_start), 64'd0);
        check_eq("ready_state", 64'(bad_ready), 64'd0);
        check_eq("operands_stable", 64'(bad_opnd), 64'd0);
        check_eq("done_in_run", 64'(bad_done), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mult_hilo_ctrl.md
Name: mult_hilo_ctrl

Overview:
Sequencing and result stage wrapped around the 32-bit Booth multiplier. Accepts a MULT request from the control unit, holds operands stable, drives the multiplier's 2-bit start code for the exact iteration window, and captures the 64-bit product into architectural HI/LO registers. Also provides the MTHI/MTLO write path and the busy/stall and done signals for the control unit. Downstream consumers (MFHI/MFLO muxing) read hi/lo directly.

Parameters:
WIDTH, 32, operand and HI/LO width
RUN_EDGES, 34, RUN-state edges per operation: 1 multiplier load, 32 iterations, 1 capture

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-low (0 = reset), sampled on rising clk
op_valid  in  1  control unit requests a MULT
op_a  in  WIDTH  multiplicand, signed
op_b  in  WIDTH  multiplier, signed
op_ready  out  1  high when a request can be accepted (state IDLE)
mult_mc  out  WIDTH  registered multiplicand to multiplier
mult_mp  out  WIDTH  registered multiplier operand to multiplier
mult_start  out  2  start code to multiplier: 2'd2 run, 2'd0 clear/idle
mult_hi  in  WIDTH  multiplier upper product
mult_lo  in  WIDTH  multiplier lower product
hi_we  in  1  MTHI write enable
lo_we  in  1  MTLO write enable
wdata  in  WIDTH  MTHI/MTLO data
hi  out  WIDTH  architectural HI register
lo  out  WIDTH  architectural LO register
busy  out  1  high while state RUN (stall for MFHI/MFLO/MULT)
done  out  1  one-cycle pulse in the cycle after HI/LO capture

Behaviour:
- Reset (reset==0 at an edge): state IDLE, cnt 0, hi 0, lo 0, mult_mc 0, mult_mp 0, done 0. Hence busy 0, mult_start 2'd0, op_ready 1. Reset mid-operation aborts without capture; the multiplier clears because mult_start returns to 0.
- States: IDLE, RUN. mult_start = 2'd2 iff state==RUN, else 2'd0. busy = (state==RUN). op_ready = (state==IDLE).
- IDLE: on an edge with op_valid==1, latch op_a->mult_mc and op_b->mult_mp, cnt<=0, go RUN. op_valid while RUN is ignored and not queued.
- RUN: each edge does cnt<=cnt+1 (6-bit). The edge with cnt==0 is the multiplier load. Edges with cnt 1..32 are the iterations. After the cnt==32 edge, mult_hi/mult_lo are final and stable.
- Capture edge (cnt==RUN_EDGES-1 = 33): hi<=mult_hi, lo<=mult_lo, done<=1, state<=IDLE, cnt<=0.
- Latency: request accepted at edge T0, HI/LO updated at edge T0+34, done high during the cycle T0+34..T0+35. A new request may be accepted at edge T0+35 at the earliest.
- mult_mc/mult_mp hold their values through RUN and until the next accept. No change while busy.
- done is 0 on every cycle except the one following a capture.
- MTHI/MTLO: on any edge with hi_we (lo_we), hi (lo)<=wdata, in IDLE or RUN. If a write coincides with the capture edge, the capture wins for both registers. A write during RUN is overwritten at capture.
- op_valid together with hi_we/lo_we in IDLE: both take effect (operand latch plus register write).
- Product is signed 64-bit {hi,lo}. No overflow flag.

Test Plan:
- Reset 0 for 2 cycles, then 1 -> hi=0, lo=0, busy=0, done=0, mult_start=0, op_ready=1.
- op_a=3, op_b=5, op_valid for 1 cycle -> busy=1 for exactly 34 cycles, mult_start=2 throughout; then hi=0x00000000, lo=0x0000000F, done pulses once.
- op_a=-2 (0xFFFFFFFE), op_b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFF2. op_a=op_b=0x80000000 -> hi=0x40000000, lo=0x00000000.
- op_valid held high continuously with 3*5 then 4*6 -> second accept occurs on the edge after the done cycle. op_ready=0 and operands unchanged during RUN. Final lo=0x18.
- hi_we=1, wdata=0xDEADBEEF at RUN cycle 10 -> hi reads 0xDEADBEEF until capture, then the product HI. hi_we at the capture edge -> product HI retained.
- Start 3*5, drive reset=0 at RUN cycle 12 -> next cycle busy=0, hi=lo=0, mult_start=0, no done pulse. A following 2*2 yields lo=4.
